// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the 640x480@60 VGA timing generator.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF =
        H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF =
        V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam logic SYNC_ACT = 1'b0;

    function automatic logic in_win(
        input logic [COORD_W-1:0] v,
        input int                 lo,
        input int                 len
    );
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register aligning sync/blank with registered pixel data.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, reset, en};
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d = stage_q;
            if (en) begin
                stage_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel tick, x/y coordinates, blanking and sync,
// plus pipeline-delayed sync copies for ROM-registered pixel paths.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int PIPE_DLY  = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start,
    output logic               line_start,
    output logic               video_on_d,
    output logic               hsync_d,
    output logic               vsync_d
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);

    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
        $error("vga_timing_gen: raster totals exceed coordinate range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..4");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               tick;
    logic               x_wrap;

    always_comb begin
        tick   = (div_q == DIV_LAST);
        x_wrap = (x_q == X_LAST);
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        x_d    = x_q;
        y_d    = y_q;
        if (tick) begin
            x_d = x_wrap ? '0 : x_q + COORD_W'(1);
            if (x_wrap) begin
                y_d = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
            end
        end
        // Sync decoded from the next coordinates so it registers with x/y.
        hs_d = in_win(x_d, H_DISPLAY + H_FRONT, H_SYNC) ? SYNC_ACT : ~SYNC_ACT;
        vs_d = in_win(y_d, V_DISPLAY + V_FRONT, V_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= ~SYNC_ACT;
            vs_q  <= ~SYNC_ACT;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign p_tick      = tick;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = (int'(x_q) < H_DISPLAY) && (int'(y_q) < V_DISPLAY);
    assign line_start  = tick && x_wrap;
    assign frame_start = line_start && (y_q == Y_LAST);

    vga_sync_delay #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL ({1'b0, ~SYNC_ACT, ~SYNC_ACT})
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .d     ({video_on, hs_q, vs_q}),
        .q     ({video_on_d, hsync_d, vsync_d})
    );

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Master raster generator for the 640x480@60 Hz VGA output. It produces the pixel-enable tick, the current pixel coordinates x/y, the blanking and sync signals, and copies of video_on/hsync/vsync delayed to match synchronous-ROM latency. Every sprite/logo/text display unit consumes x/y from this block and returns rgb plus an "_on" flag to the pixel mux, so this block drives the coordinate side of that interface.

Parameters:
CLK_DIV, 2, system clocks per pixel (50 MHz clk -> 25 MHz pixel), must be >=1
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
PIPE_DLY, 1, pixel ticks of delay on the *_d outputs (0..4) to align sync with ROM-registered rgb

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
p_tick  out  1  one-clk pulse once every CLK_DIV clocks; x/y advance on it
x  out  10  current pixel column 0..H_TOTAL-1
y  out  10  current line 0..V_TOTAL-1
video_on  out  1  x<H_DISPLAY && y<V_DISPLAY, aligned with x/y
hsync  out  1  active-low horizontal sync, aligned with x/y
vsync  out  1  active-low vertical sync, aligned with x/y
frame_start  out  1  one-clk pulse on the p_tick where x/y wrap to 0/0
line_start  out  1  one-clk pulse on the p_tick where x wraps to 0
video_on_d  out  1  video_on delayed PIPE_DLY pixel ticks
hsync_d  out  1  hsync delayed PIPE_DLY pixel ticks (drive to pin)
vsync_d  out  1  vsync delayed PIPE_DLY pixel ticks (drive to pin)

Behaviour:
- Clock/reset: single clock clk; reset is asynchronous and active-high; all state clears immediately on reset assertion, resumes on first clk edge after deassertion.
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Counters sized 10 bits; elaboration error if totals exceed 1024.
- Divider: counter div 0..CLK_DIV-1, increments each clk, wraps to 0; p_tick = (div == CLK_DIV-1). CLK_DIV=1 -> p_tick constant 1 out of reset.
- x increments on p_tick; at x==H_TOTAL-1 wraps to 0 and y increments; at y==V_TOTAL-1 with x wrap, y wraps to 0.
- x, y, hsync, vsync are registered and change only on the clk edge that consumes p_tick; held otherwise.
- hsync = 0 iff x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751); vsync = 0 iff y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491).
- video_on combinational from registered x/y.
- line_start = p_tick && x==H_TOTAL-1; frame_start = line_start && y==V_TOTAL-1 (pulse coincides with the tick that produces 0/0).
- *_d outputs: PIPE_DLY-stage shift register advanced only on p_tick; PIPE_DLY=0 -> pass-through.
- Reset values: div=0, x=0, y=0, p_tick=0 (1 if CLK_DIV=1), hsync=1, vsync=1, video_on=1 (x=y=0), frame_start=0, line_start=0, all delay stages reset to video_on_d=0, hsync_d=1, vsync_d=1.
- Reset mid-frame: raster restarts at 0/0 with no partial sync pulse carried over; delay line flushed to inactive values.
- Timing: one full frame = H_TOTAL*V_TOTAL*CLK_DIV clk cycles (840000 at defaults).

Decomposition:
- Package vga_timing_pkg: default porch/sync/display constants, derived H_TOTAL/V_TOTAL, sync active level constant (0), coordinate width (10).
- One sub-module: vga_sync_delay (parametric depth, enable = p_tick, per-bit reset value) for the *_d outputs.

Test Plan:
- Assert reset for 5 clk, release -> x=y=0, hsync=vsync=1, video_on=1; p_tick first high on 2nd clk, then every 2 clk.
- Run one line -> x visits 0..799 once per 2 clk; video_on falls when x goes 639->640; line_start pulses at x=799 tick; y 0->1.
- Run one line -> hsync low from x=656 through x=751, exactly 96 ticks = 192 clk; vsync stays 1.
- Run full frame -> vsync low for y=490..491 (1600 ticks); frame_start single pulse after 840000 clk; x=y=0 the following cycle.
- PIPE_DLY=1 -> hsync_d/vsync_d/video_on_d equal hsync/vsync/video_on shifted exactly 1 p_tick (2 clk); PIPE_DLY=0 -> identical.
- Assert reset at x=700,y=491 (mid-hsync, mid-vsync) -> hsync, vsync, hsync_d, vsync_d go 1 asynchronously, x=y=0; after release raster restarts and the next hsync starts at x=656.
